// File: rtl/phase1_datapath.sv
// Phase-1 single-bus CPU datapath.
// General registers R1/R3/R5 plus PC, IR, MAR, MDR, Y and a double-width Z
// all share one bus. The ALU takes A from Y and B from the bus and writes Z.
// Every load, drive and ALU select comes from an external sequencer; this
// block does no decoding of its own.
module phase1_datapath #(
    parameter int WIDTH = 32
) (
    input  logic                 Clock,
    input  logic                 Clear,
    input  logic                 R1in,
    input  logic                 R3in,
    input  logic                 R5in,
    input  logic                 MARin,
    input  logic                 PCin,
    input  logic                 IRin,
    input  logic                 Yin,
    input  logic                 Zin,
    input  logic                 MDRin,
    input  logic                 IncrementPC,
    input  logic                 Read,
    input  logic                 PCout,
    input  logic                 ZLOout,
    input  logic                 MDRout,
    input  logic                 R3out,
    input  logic                 R5out,
    input  logic [4:0]           ALUControl,
    input  logic [WIDTH-1:0]     Mdatain,
    output logic [WIDTH-1:0]     R1_data_out,
    output logic [WIDTH-1:0]     R3_data_out,
    output logic [WIDTH-1:0]     R5_data_out,
    output logic [WIDTH-1:0]     big_boy_bus,
    output logic [WIDTH-1:0]     MDR_data_in,
    output logic [WIDTH-1:0]     MDR_data_out,
    output logic [WIDTH-1:0]     Y_data_out,
    output logic [2*WIDTH-1:0]   Z_data_out,
    output logic [WIDTH-1:0]     ZLO_data_out
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] W_FULL = (SW+1)'(WIDTH);

    // ALU operation codes
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHL  = 5'b00101;
    localparam logic [4:0] OP_ROR  = 5'b00110;
    localparam logic [4:0] OP_ROL  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_DIV  = 5'b01010;
    localparam logic [4:0] OP_NEG  = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b01100;

    logic [WIDTH-1:0]   r_r1;
    logic [WIDTH-1:0]   r_r3;
    logic [WIDTH-1:0]   r_r5;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_ir;
    logic [WIDTH-1:0]   r_mar;
    logic [WIDTH-1:0]   r_mdr;
    logic [WIDTH-1:0]   r_y;
    logic [2*WIDTH-1:0] r_z;

    logic [WIDTH-1:0]   w_bus;
    logic [WIDTH-1:0]   w_mdr_in;
    logic [2*WIDTH-1:0] w_alu;

    // ALU helper terms
    logic [SW-1:0]             w_sh;
    logic [SW:0]               w_inv_sh;
    logic [WIDTH-1:0]          w_ror;
    logic [WIDTH-1:0]          w_rol;
    logic [WIDTH-1:0]          w_sra;
    logic [2*WIDTH-1:0]        w_a_ext;
    logic [2*WIDTH-1:0]        w_b_ext;
    logic [2*WIDTH-1:0]        w_mul;
    logic signed [WIDTH-1:0]   w_div_q;
    logic signed [WIDTH-1:0]   w_div_r;

    // IR and MAR are held for a later phase but have no consumer here yet.
    logic w_unused_ir_mar;
    assign w_unused_ir_mar = ^{r_ir, r_mar};

    // Bus source select: fixed priority PC > ZLO > MDR > R3 > R5, idle is 0
    always_comb begin
        w_bus = '0;
        if (PCout)
            w_bus = r_pc;
        else if (ZLOout)
            w_bus = r_z[WIDTH-1:0];
        else if (MDRout)
            w_bus = r_mdr;
        else if (R3out)
            w_bus = r_r3;
        else if (R5out)
            w_bus = r_r5;
    end

    // MDR input mux: memory read data or the bus
    assign w_mdr_in = Read ? Mdatain : w_bus;

    // Shift/rotate amount comes from the low bits of operand B
    assign w_sh     = w_bus[SW-1:0];
    assign w_inv_sh = W_FULL - {1'b0, w_sh};
    // A shift by the full width yields 0, so w_sh=0 rotates to A itself
    assign w_ror    = (r_y >> w_sh) | (r_y << w_inv_sh);
    assign w_rol    = (r_y << w_sh) | (r_y >> w_inv_sh);
    assign w_sra    = $signed(r_y) >>> w_sh;

    // Signed product via sign-extended operands, truncated to double width
    assign w_a_ext  = {{WIDTH{r_y[WIDTH-1]}}, r_y};
    assign w_b_ext  = {{WIDTH{w_bus[WIDTH-1]}}, w_bus};
    assign w_mul    = w_a_ext * w_b_ext;

    assign w_div_q  = $signed(r_y) / $signed(w_bus);
    assign w_div_r  = $signed(r_y) % $signed(w_bus);

    // ALU: A = Y, B = bus; upper half of the result is 0 except MUL/DIV
    always_comb begin
        w_alu = '0;
        case (ALUControl)
            OP_ADD:  w_alu = {{WIDTH{1'b0}}, r_y + w_bus};
            OP_SUB:  w_alu = {{WIDTH{1'b0}}, r_y - w_bus};
            OP_AND:  w_alu = {{WIDTH{1'b0}}, r_y & w_bus};
            OP_OR:   w_alu = {{WIDTH{1'b0}}, r_y | w_bus};
            OP_SHR:  w_alu = {{WIDTH{1'b0}}, r_y >> w_sh};
            OP_SHL:  w_alu = {{WIDTH{1'b0}}, r_y << w_sh};
            OP_ROR:  w_alu = {{WIDTH{1'b0}}, w_ror};
            OP_ROL:  w_alu = {{WIDTH{1'b0}}, w_rol};
            OP_SHRA: w_alu = {{WIDTH{1'b0}}, w_sra};
            OP_MUL:  w_alu = w_mul;
            OP_DIV: begin
                // Divide by zero defines the result as all zeros
                if (w_bus != '0)
                    w_alu = {w_div_r, w_div_q};
            end
            OP_NEG:  w_alu = {{WIDTH{1'b0}}, {WIDTH{1'b0}} - w_bus};
            OP_NOT:  w_alu = {{WIDTH{1'b0}}, ~w_bus};
            default: w_alu = '0;
        endcase
    end

    // Register file: each register loads on its strobe, all clear asynchronously
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_r1  <= '0;
            r_r3  <= '0;
            r_r5  <= '0;
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_z   <= '0;
        end else begin
            if (R1in)  r_r1  <= w_bus;
            if (R3in)  r_r3  <= w_bus;
            if (R5in)  r_r5  <= w_bus;
            if (IRin)  r_ir  <= w_bus;
            if (MARin) r_mar <= w_bus;
            if (Yin)   r_y   <= w_bus;
            if (MDRin) r_mdr <= w_mdr_in;
            if (Zin)   r_z   <= w_alu;
            if (PCin)  r_pc  <= IncrementPC ? (w_bus + WIDTH'(1)) : w_bus;
        end
    end

    assign R1_data_out  = r_r1;
    assign R3_data_out  = r_r3;
    assign R5_data_out  = r_r5;
    assign big_boy_bus  = w_bus;
    assign MDR_data_in  = w_mdr_in;
    assign MDR_data_out = r_mdr;
    assign Y_data_out   = r_y;
    assign Z_data_out   = r_z;
    assign ZLO_data_out = r_z[WIDTH-1:0];

endmodule

// File: tb/tb_phase1_datapath.sv
// Bench for phase1_datapath: fixed scenarios plus randomized ALU and
// register traffic compared against an arithmetic reference model.
module tb_phase1_datapath;

    logic        Clock;
    logic        Clear;
    logic        R1in, R3in, R5in, MARin, PCin, IRin, Yin, Zin, MDRin;
    logic        IncrementPC, Read;
    logic        PCout, ZLOout, MDRout, R3out, R5out;
    logic [4:0]  ALUControl;
    logic [31:0] Mdatain;
    logic [31:0] R1_data_out, R3_data_out, R5_data_out, big_boy_bus;
    logic [31:0] MDR_data_in, MDR_data_out, Y_data_out, ZLO_data_out;
    logic [63:0] Z_data_out;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    phase1_datapath #(.WIDTH(32)) dut (
        .Clock(Clock), .Clear(Clear),
        .R1in(R1in), .R3in(R3in), .R5in(R5in),
        .MARin(MARin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .MDRin(MDRin), .IncrementPC(IncrementPC), .Read(Read),
        .PCout(PCout), .ZLOout(ZLOout), .MDRout(MDRout),
        .R3out(R3out), .R5out(R5out),
        .ALUControl(ALUControl), .Mdatain(Mdatain),
        .R1_data_out(R1_data_out), .R3_data_out(R3_data_out),
        .R5_data_out(R5_data_out), .big_boy_bus(big_boy_bus),
        .MDR_data_in(MDR_data_in), .MDR_data_out(MDR_data_out),
        .Y_data_out(Y_data_out), .Z_data_out(Z_data_out),
        .ZLO_data_out(ZLO_data_out)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] alu_ref(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic [63:0] u;
        longint p;
        int s, q, m;
        s = int'(b[4:0]);
        r = a;
        case (op)
            5'd0: return {32'h0, a + b};
            5'd1: return {32'h0, a - b};
            5'd2: return {32'h0, a & b};
            5'd3: return {32'h0, a | b};
            5'd4: begin u = {32'h0, a} / (64'd1 << s); return {32'h0, u[31:0]}; end
            5'd5: begin u = {32'h0, a} * (64'd1 << s); return {32'h0, u[31:0]}; end
            5'd6: begin for (int i = 0; i < s; i++) r = {r[0], r[31:1]}; return {32'h0, r}; end
            5'd7: begin for (int i = 0; i < s; i++) r = {r[30:0], r[31]}; return {32'h0, r}; end
            5'd8: begin for (int i = 0; i < s; i++) r = {r[31], r[31:1]}; return {32'h0, r}; end
            5'd9: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
            5'd10: begin
                if (b == 32'h0) return 64'h0;
                q = $signed(a) / $signed(b);
                m = $signed(a) % $signed(b);
                return {m, q};
            end
            5'd11: return {32'h0, 32'h0 - b};
            5'd12: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        R1in = 0; R3in = 0; R5in = 0; MARin = 0; PCin = 0; IRin = 0;
        Yin = 0; Zin = 0; MDRin = 0; IncrementPC = 0; Read = 0;
        PCout = 0; ZLOout = 0; MDRout = 0; R3out = 0; R5out = 0;
        ALUControl = 5'd0; Mdatain = 32'h0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle();
        Read = 1; MDRin = 1; Mdatain = v;
        tick();
        idle();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        MDRout = 1; Yin = 1;
        tick();
        idle();
    endtask

    task automatic set_pc(input logic [31:0] v);
        load_mdr(v);
        MDRout = 1; PCin = 1;
        tick();
        idle();
    endtask

    task automatic alu_exec(input logic [4:0] op, input logic [31:0] b);
        load_mdr(b);
        MDRout = 1; ALUControl = op; Zin = 1;
        tick();
        idle();
    endtask

    // Loads MDR then moves it into R1 (sel 0), R3 (sel 1) or R5 (sel 2).
    // Checks the bus during the transfer and the destination afterwards.
    task automatic load_reg(input int sel, input logic [31:0] v, input string tag);
        logic [31:0] got;
        load_mdr(v);
        MDRout = 1;
        case (sel)
            0: R1in = 1;
            1: R3in = 1;
            default: R5in = 1;
        endcase
        #1;
        checks++;
        if (big_boy_bus !== v) begin
            failures++;
            $display("FAIL %s_bus: got %h expected %h", tag, big_boy_bus, v);
        end
        tick();
        idle();
        got = (sel == 0) ? R1_data_out : (sel == 1) ? R3_data_out : R5_data_out;
        checks++;
        if (got !== v) begin
            failures++;
            $display("FAIL %s_reg%0d: got %h expected %h", tag, sel, got, v);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [63:0] obs[8];
        string nm[8];
        idle();
        Clear = 1'b1;
        #1;
        PCout = 1;
        #1;
        obs[0] = {32'h0, R1_data_out};  nm[0] = "r1";
        obs[1] = {32'h0, R3_data_out};  nm[1] = "r3";
        obs[2] = {32'h0, R5_data_out};  nm[2] = "r5";
        obs[3] = {32'h0, MDR_data_out}; nm[3] = "mdr";
        obs[4] = {32'h0, Y_data_out};   nm[4] = "y";
        obs[5] = Z_data_out;            nm[5] = "z";
        obs[6] = {32'h0, ZLO_data_out}; nm[6] = "zlo";
        obs[7] = {32'h0, big_boy_bus};  nm[7] = "pc_on_bus";
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== 64'h0) begin
                failures++;
                $display("FAIL reset_%s: got %h expected 0", nm[i], obs[i]);
            end
        end
        idle();
        tick();
        Clear = 1'b0;
    endtask

    task automatic test_register_load();
        int sel;
        logic [31:0] v;
        do_reset();
        load_reg(1, 32'hFFFFFF5A, "load_r3");
        load_reg(2, 32'h00000002, "load_r5");
        load_reg(0, 32'h00000018, "load_r1");
        // random traffic through the three registers, restoring R3/R5 after
        for (int k = 0; k < 8; k++) begin
            sel = int'($urandom_range(0, 2));
            v = $urandom;
            load_reg(sel, v, "rand_load");
        end
        load_reg(1, 32'hFFFFFF5A, "restore_r3");
        load_reg(2, 32'h00000002, "restore_r5");
    endtask

    task automatic test_shra_instruction();
        // T0
        idle();
        PCout = 1; MARin = 1; Zin = 1; ALUControl = 5'b00000;
        tick();
        idle();
        checks++;
        if (Z_data_out !== 64'h0) begin
            failures++;
            $display("FAIL fetch_t0_z: got %h expected %h", Z_data_out, 64'h0);
        end
        // T1
        ZLOout = 1; PCin = 1; IncrementPC = 1; Read = 1; MDRin = 1;
        Mdatain = 32'h28918000;
        tick();
        idle();
        checks++;
        if (MDR_data_out !== 32'h28918000) begin
            failures++;
            $display("FAIL fetch_t1_mdr: got %h expected %h", MDR_data_out, 32'h28918000);
        end
        PCout = 1;
        #1;
        checks++;
        if (big_boy_bus !== 32'h1) begin
            failures++;
            $display("FAIL fetch_t1_pc: got %h expected %h", big_boy_bus, 32'h1);
        end
        idle();
        // T2
        MDRout = 1; IRin = 1;
        #1;
        checks++;
        if (big_boy_bus !== 32'h28918000) begin
            failures++;
            $display("FAIL fetch_t2_bus: got %h expected %h", big_boy_bus, 32'h28918000);
        end
        tick();
        idle();
        // T3
        R3out = 1; Yin = 1;
        tick();
        idle();
        checks++;
        if (Y_data_out !== 32'hFFFFFF5A) begin
            failures++;
            $display("FAIL shra_t3_y: got %h expected %h", Y_data_out, 32'hFFFFFF5A);
        end
        // T4
        R5out = 1; ALUControl = 5'b01000; Zin = 1;
        tick();
        idle();
        checks++;
        if (Z_data_out !== 64'h00000000FFFFFFD6) begin
            failures++;
            $display("FAIL shra_t4_z: got %h expected %h", Z_data_out, 64'h00000000FFFFFFD6);
        end
        // T5
        ZLOout = 1; R1in = 1;
        tick();
        idle();
        checks++;
        if (R1_data_out !== 32'hFFFFFFD6) begin
            failures++;
            $display("FAIL shra_t5_r1: got %h expected %h", R1_data_out, 32'hFFFFFFD6);
        end
    endtask

    task automatic test_alu_sweep();
        logic [4:0]  ops[6];
        logic [31:0] res[6];
        ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00101, 5'b00100};
        res = '{32'h10, 32'h8, 32'h4, 32'hC, 32'hC0, 32'h0};
        load_y(32'h0000000C);
        for (int i = 0; i < 6; i++) begin
            alu_exec(ops[i], 32'h4);
            checks++;
            if (Z_data_out !== {32'h0, res[i]}) begin
                failures++;
                $display("FAIL sweep_op%0d: got %h expected %h", ops[i], Z_data_out, {32'h0, res[i]});
            end
        end
        load_y(32'hFFFFFFFD);
        alu_exec(5'b01001, 32'h5);
        checks++;
        if (Z_data_out !== 64'hFFFFFFFFFFFFFFF1) begin
            failures++;
            $display("FAIL sweep_mul: got %h expected %h", Z_data_out, 64'hFFFFFFFFFFFFFFF1);
        end
        load_y(32'd13);
        alu_exec(5'b01010, 32'd4);
        checks++;
        if (Z_data_out[31:0] !== 32'd3 || Z_data_out[63:32] !== 32'd1) begin
            failures++;
            $display("FAIL sweep_div: got %h expected %h", Z_data_out, {32'd1, 32'd3});
        end
        alu_exec(5'b01101, 32'd4);
        checks++;
        if (Z_data_out !== 64'h0) begin
            failures++;
            $display("FAIL sweep_undefined_op: got %h expected 0", Z_data_out);
        end
        alu_exec(5'b01100, 32'h0F0F0000);
        checks++;
        if (Z_data_out !== 64'h00000000F0F0FFFF) begin
            failures++;
            $display("FAIL sweep_not: got %h expected %h", Z_data_out, 64'h00000000F0F0FFFF);
        end
        alu_exec(5'b01010, 32'd0);
        checks++;
        if (Z_data_out !== 64'h0) begin
            failures++;
            $display("FAIL sweep_div_zero: got %h expected 0", Z_data_out);
        end
    endtask

    task automatic test_random_alu();
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [63:0] e;
        for (int k = 0; k < 60; k++) begin
            op = 5'($urandom_range(0, 14));
            a = $urandom;
            b = $urandom;
            if (op == 5'd10 && $urandom_range(0, 5) == 0) b = 32'h0;
            if (op == 5'd10 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'h3;
            if ($urandom_range(0, 3) == 0) b = {27'h0, b[4:0]};
            load_y(a);
            exp_q.push_back(alu_ref(op, a, b));
            alu_exec(op, b);
            e = exp_q.pop_front();
            checks++;
            if (Z_data_out !== e) begin
                failures++;
                $display("FAIL rand_alu op=%0d a=%h b=%h: got %h expected %h", op, a, b, Z_data_out, e);
            end
        end
    endtask

    task automatic test_bus_priority();
        logic [4:0]  masks[8];
        logic [31:0] res[8];
        load_reg(1, 32'h33333333, "prio_r3");
        load_reg(2, 32'h55555555, "prio_r5");
        load_y(32'h00001000);
        alu_exec(5'b00000, 32'h00000234);
        set_pc(32'h00000040);
        load_mdr(32'hABCD0001);
        // mask bits: {PCout, ZLOout, MDRout, R3out, R5out}
        masks = '{5'b11111, 5'b01111, 5'b00111, 5'b00011,
                  5'b00001, 5'b10001, 5'b00000, 5'b01001};
        res   = '{32'h40, 32'h1234, 32'hABCD0001, 32'h33333333,
                  32'h55555555, 32'h40, 32'h0, 32'h1234};
        for (int i = 0; i < 8; i++) begin
            idle();
            {PCout, ZLOout, MDRout, R3out, R5out} = masks[i];
            #1;
            checks++;
            if (big_boy_bus !== res[i] || MDR_data_in !== res[i]) begin
                failures++;
                $display("FAIL bus_prio mask=%b: bus %h mdr_in %h expected %h",
                         masks[i], big_boy_bus, MDR_data_in, res[i]);
            end
        end
        idle();
    endtask

    task automatic test_pc_wrap();
        set_pc(32'hFFFFFFFF);
        PCout = 1;
        #1;
        checks++;
        if (big_boy_bus !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL pc_preload: got %h expected %h", big_boy_bus, 32'hFFFFFFFF);
        end
        PCin = 1; IncrementPC = 1;
        tick();
        idle();
        PCout = 1;
        #1;
        checks++;
        if (big_boy_bus !== 32'h0) begin
            failures++;
            $display("FAIL pc_wrap: got %h expected 0", big_boy_bus);
        end
        idle();
    endtask

    task automatic test_load_and_drive();
        load_reg(1, 32'h0BADF00D, "self_r3");
        R3out = 1; R3in = 1;
        tick();
        idle();
        checks++;
        if (R3_data_out !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL self_r3_hold: got %h expected %h", R3_data_out, 32'h0BADF00D);
        end
        set_pc(32'h00000007);
        for (int i = 0; i < 2; i++) begin
            PCout = 1; PCin = 1; IncrementPC = 1;
            tick();
            idle();
        end
        PCout = 1;
        #1;
        checks++;
        if (big_boy_bus !== 32'h9) begin
            failures++;
            $display("FAIL self_pc_incr: got %h expected %h", big_boy_bus, 32'h9);
        end
        idle();
    endtask

    task automatic test_async_reset();
        logic [63:0] obs[8];
        string nm[8];
        load_reg(0, 32'h11111111, "pre_r1");
        load_reg(1, 32'h33333333, "pre_r3");
        load_reg(2, 32'h55555555, "pre_r5");
        load_y(32'h00000003);
        alu_exec(5'b01001, 32'h7FFFFFFF);
        set_pc(32'h00000100);
        load_mdr(32'hCAFEBABE);
        @(posedge Clock);
        #3;
        Clear = 1'b1;
        PCout = 1;
        #1;
        obs[0] = {32'h0, R1_data_out};  nm[0] = "r1";
        obs[1] = {32'h0, R3_data_out};  nm[1] = "r3";
        obs[2] = {32'h0, R5_data_out};  nm[2] = "r5";
        obs[3] = {32'h0, MDR_data_out}; nm[3] = "mdr";
        obs[4] = {32'h0, Y_data_out};   nm[4] = "y";
        obs[5] = Z_data_out;            nm[5] = "z";
        obs[6] = {32'h0, ZLO_data_out}; nm[6] = "zlo";
        obs[7] = {32'h0, big_boy_bus};  nm[7] = "pc_on_bus";
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== 64'h0) begin
                failures++;
                $display("FAIL async_clear_%s: got %h expected 0", nm[i], obs[i]);
            end
        end
        // strobes asserted while Clear is held must not load
        idle();
        Read = 1; MDRin = 1; Mdatain = 32'h0000FFFF;
        tick();
        checks++;
        if (MDR_data_out !== 32'h0) begin
            failures++;
            $display("FAIL clear_hold_mdr: got %h expected 0", MDR_data_out);
        end
        Clear = 1'b0;
        tick();
        checks++;
        if (MDR_data_out !== 32'h0000FFFF) begin
            failures++;
            $display("FAIL resume_mdr: got %h expected %h", MDR_data_out, 32'h0000FFFF);
        end
        idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        Clear = 1'b1;
        idle();
        test_reset();
        test_register_load();
        test_shra_instruction();
        test_alu_sweep();
        test_random_alu();
        test_bus_priority();
        test_pc_wrap();
        test_load_and_drive();
        test_async_reset();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
